// File: rtl/pdm_clk_gen_if.sv
// rtl/pdm_clk_gen_if.sv - control and strobe bundle for the PDM mic clock generator
interface pdm_clk_gen_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [CNT_W-1:0] half_div;
    logic             div_load;
    logic             mic_clk;
    logic             rise_stb;
    logic             fall_stb;
    logic             smp_l_stb;
    logic             smp_r_stb;
    logic             active;
    logic             div_busy;

    modport master (
        output en, half_div, div_load,
        input  mic_clk, rise_stb, fall_stb, smp_l_stb, smp_r_stb, active, div_busy
    );

    modport slave (
        input  en, half_div, div_load,
        output mic_clk, rise_stb, fall_stb, smp_l_stb, smp_r_stb, active, div_busy
    );
endinterface

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - programmable PDM mic clock with edge and delayed sample strobes
module pdm_clk_gen #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 25,
    parameter int SMP_DLY     = 4
) (
    input logic          clk,
    input logic          reset,
    pdm_clk_gen_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             div_busy_q, div_busy_d;
    logic             mic_clk_q, mic_clk_d;
    logic             active_q, active_d;
    logic [SMP_DLY:0] sr_l_q, sr_l_d;
    logic [SMP_DLY:0] sr_r_q, sr_r_d;
    logic [SMP_DLY+1:0] sr_l_ext, sr_r_ext;
    logic             rise_d, fall_d, apply;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        div_busy_d = div_busy_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        apply      = 1'b0;

        case (state_q)
            ST_IDLE: apply = bus.en;
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = cur_div_q - ONE;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    if (bus.en) apply = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Divisor is only swapped at a rising edge so a period never mixes halves.
        if (apply) begin
            state_d    = ST_HIGH;
            cur_div_d  = pend_div_q;
            cnt_d      = pend_div_q - ONE;
            rise_d     = 1'b1;
            div_busy_d = 1'b0;
        end

        // A load on the apply cycle wins over the clear: it stays pending.
        if (bus.div_load) begin
            pend_div_d = (bus.half_div == '0) ? ONE : bus.half_div;
            div_busy_d = 1'b1;
        end

        mic_clk_d = (state_d == ST_HIGH);
        active_d  = (state_d != ST_IDLE);

        // Bit 0 is the edge strobe itself; bit SMP_DLY is its delayed sample strobe.
        sr_l_ext = {sr_l_q, rise_d};
        sr_r_ext = {sr_r_q, fall_d};
        sr_l_d   = sr_l_ext[SMP_DLY:0];
        sr_r_d   = sr_r_ext[SMP_DLY:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_div_q  <= DIV_RST;
            pend_div_q <= DIV_RST;
            div_busy_q <= 1'b0;
            mic_clk_q  <= 1'b0;
            active_q   <= 1'b0;
            sr_l_q     <= '0;
            sr_r_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            div_busy_q <= div_busy_d;
            mic_clk_q  <= mic_clk_d;
            active_q   <= active_d;
            sr_l_q     <= sr_l_d;
            sr_r_q     <= sr_r_d;
        end
    end

    assign bus.mic_clk   = mic_clk_q;
    assign bus.rise_stb  = sr_l_q[0];
    assign bus.fall_stb  = sr_r_q[0];
    assign bus.smp_l_stb = sr_l_q[SMP_DLY];
    assign bus.smp_r_stb = sr_r_q[SMP_DLY];
    assign bus.active    = active_q;
    assign bus.div_busy  = div_busy_q;
endmodule
